// File: rtl/updown_sched_pkg.sv
// Shared types and default widths for the up/down pair scheduler.
// Macro UPDOWN_SCHED_CROSS_STOP_EN (optional) enables early stop when the pair's values meet.
package updown_sched_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_VAL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_COUNT = 1'b0,
    OP_SWAP  = 1'b1
  } op_t;

  // A single requester still needs a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/updown_pair_sched_rr_arbiter.sv
// Rotating-priority picker: first asserted request strictly after i_rr_ptr, wrapping.
module rr_arbiter
  import updown_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan from the requester after the pointer; the first hit wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_rr_ptr) + k) % NUM_REQ]) begin
        o_grant[(int'(i_rr_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx   = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/updown_pair_sched.sv
// Round-robin scheduler sharing one up/down counter pair between requesters.
// Optional macro UPDOWN_SCHED_CROSS_STOP_EN: stop a COUNT burst once up_val == down_val.
module updown_pair_sched
  import updown_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int VAL_W   = DEF_VAL_W
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_req_op,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_early_stop,
  output logic                     o_busy,
  output logic                     o_swap,
  output logic                     o_enable,
  input  logic [VAL_W-1:0]         i_up_val,
  input  logic [VAL_W-1:0]         i_down_val
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             r_state;
  op_t                r_op;
  logic [IDX_W-1:0]   r_winner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [LEN_W-1:0]   r_remaining;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_enable;
  logic               r_swap;
  logic               r_early_stop;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic [LEN_W-1:0]   w_sel_len;
  op_t                w_sel_op;
  logic               w_cross;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  assign w_sel_len = i_req_len[int'(w_arb_idx)*LEN_W +: LEN_W];
  assign w_sel_op  = op_t'(i_req_op[w_arb_idx]);

`ifdef UPDOWN_SCHED_CROSS_STOP_EN
  // Only live COUNT cycles can stop early; a len=0 pass-through never reports it
  assign w_cross = (r_state == ST_RUN) && (r_op == OP_COUNT) &&
                   (r_remaining != '0) && (i_up_val == i_down_val);
`else
  logic w_unused_vals;
  assign w_unused_vals = ^{i_up_val, i_down_val};
  assign w_cross       = 1'b0;
`endif

  // Scheduler FSM with all handshake outputs registered
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_COUNT;
      r_winner     <= '0;
      r_rr_ptr     <= IDX_W'(NUM_REQ - 1);
      r_remaining  <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_busy       <= 1'b0;
      r_enable     <= 1'b0;
      r_swap       <= 1'b0;
      r_early_stop <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done       <= '0;
          r_early_stop <= 1'b0;
          if (w_arb_valid) begin
            r_state     <= ST_RUN;
            r_winner    <= w_arb_idx;
            r_op        <= w_sel_op;
            r_remaining <= w_sel_len;
            r_gnt       <= w_arb_grant;
            r_busy      <= 1'b1;
            r_swap      <= (w_sel_op == OP_SWAP);
            r_enable    <= (w_sel_op == OP_SWAP) || (w_sel_len != '0);
          end else begin
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_enable <= 1'b0;
            r_swap   <= 1'b0;
          end
        end
        ST_RUN: begin
          // remaining==1 marks the last enabled step; 0 is the empty-burst pass-through
          if ((r_op == OP_SWAP) || w_cross || (r_remaining <= LEN_W'(1))) begin
            r_state      <= ST_DONE;
            r_enable     <= 1'b0;
            r_swap       <= 1'b0;
            r_done       <= r_gnt;
            r_early_stop <= w_cross;
          end else begin
            r_remaining <= r_remaining - LEN_W'(1);
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_rr_ptr     <= r_winner;
          r_gnt        <= '0;
          r_done       <= '0;
          r_busy       <= 1'b0;
          r_early_stop <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_gnt        <= '0;
          r_done       <= '0;
          r_busy       <= 1'b0;
          r_enable     <= 1'b0;
          r_swap       <= 1'b0;
          r_early_stop <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_swap       = r_swap;
  assign o_enable     = r_enable & ~w_cross;
  assign o_early_stop = r_early_stop;

endmodule

// File: tb/tb_updown_pair_sched.sv
// Self-checking bench: acts as the counter pair and predicts each transaction from the scheduling rules.
module tb_updown_pair_sched;

  localparam int NR = 2;
  localparam int LW = 4;
  localparam int VW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req, req_op, gnt, done;
  logic [NR*LW-1:0] req_len;
  logic             early_stop, busy, swap, enable;
  logic [VW-1:0]    pair_up, pair_down, pl_up, pl_down;
  logic             pl_en;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr;
  logic [VW-1:0] m_up, m_down;

  updown_pair_sched #(.NUM_REQ(NR), .LEN_W(LW), .VAL_W(VW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_req_op     (req_op),
    .i_req_len    (req_len),
    .o_gnt        (gnt),
    .o_done       (done),
    .o_early_stop (early_stop),
    .o_busy       (busy),
    .o_swap       (swap),
    .o_enable     (enable),
    .i_up_val     (pair_up),
    .i_down_val   (pair_down)
  );

  always #5 clk = ~clk;

  // The counter pair being shared: swap exchanges, plain enable counts up/down
  always @(posedge clk) begin
    if (pl_en) begin
      pair_up   <= pl_up;
      pair_down <= pl_down;
    end else if (enable) begin
      if (swap) begin
        pair_up   <= pair_down;
        pair_down <= pair_up;
      end else begin
        pair_up   <= pair_up + 1'b1;
        pair_down <= pair_down - 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] mask, input int ptr);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic preload(input logic [VW-1:0] u, input logic [VW-1:0] d);
    req = '0; pl_up = u; pl_down = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0; m_up = u; m_down = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0; m_ptr = NR - 1;
  endtask

  // Entered at a negedge with the DUT idle; returns at the next idle negedge
  task automatic run_txn(input logic [NR-1:0] mask, input logic [NR-1:0] ops,
                         input logic [NR*LW-1:0] lens, input bit hold);
    int w, len, en, run, mk;
    bit op, early;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    req = mask; req_op = ops; req_len = lens;
    w = pick(mask, m_ptr);
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    op = ops[w];
    len = int'(lens[w*LW +: LW]);
    early = 1'b0;
    mk = (1 << VW) - 1;
    if (op) begin
      en = 1; run = 1;
    end else begin
      en = len; run = (len == 0) ? 1 : len;
`ifdef UPDOWN_SCHED_CROSS_STOP_EN
      for (int k = 0; k < len; k++) begin
        if (((int'(m_up) + k) & mk) == ((int'(m_down) - k) & mk)) begin
          en = k; run = k + 1; early = 1'b1;
          break;
        end
      end
`endif
    end
    for (int c = 1; c <= run; c++) begin
      @(negedge clk);
      chk("run_gnt", 32'(gnt), 32'(1 << w));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_enable", 32'(enable), 32'(c <= en));
      chk("run_swap", 32'(swap), 32'(op && (c <= en)));
      chk("run_done", 32'(done), 32'd0);
      if (!hold) req = '0;
      req_op  = NR'($urandom);
      req_len = (NR*LW)'($urandom);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(1 << w));
    chk("done_gnt", 32'(gnt), 32'(1 << w));
    chk("done_early", 32'(early_stop), 32'(early));
    chk("done_enable", 32'(enable), 32'd0);
    m_ptr = w;
    if (op) begin
      {m_up, m_down} = {m_down, m_up};
    end else begin
      m_up   = m_up + VW'(en);
      m_down = m_down - VW'(en);
    end
    @(negedge clk);
    chk("pair_up", 32'(pair_up), 32'(m_up));
    chk("pair_down", 32'(pair_down), 32'(m_down));
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_len = '0;
    pl_en = 1'b0; pl_up = '0; pl_down = '0;
    m_ptr = NR - 1; m_up = '0; m_down = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_early", 32'(early_stop), 32'd0);
    rst = 1'b0;

    // COUNT len=3 from 0/0
    preload(4'd0, 4'd0);
    run_txn(2'b01, 2'b00, 8'h03, 1'b0);

    // Two held requesters alternate, starting with 0 after reset
    do_reset();
    for (int i = 0; i < 4; i++) run_txn(2'b11, 2'b00, 8'h11, 1'b1);

    // SWAP by requester 1
    preload(4'd5, 4'd9);
    run_txn(2'b10, 2'b10, 8'h70, 1'b0);

    // Empty burst, then a full-length burst that wraps
    preload(4'd7, 4'd2);
    run_txn(2'b01, 2'b00, 8'h50, 1'b0);
    preload(4'd14, 4'd3);
    run_txn(2'b01, 2'b00, 8'h0F, 1'b0);

    // Reset in cycle 2 of a len=10 burst
    do_reset();
    preload(4'd0, 4'd1);
    req = 2'b11; req_op = 2'b00; req_len = 8'h3A;
    @(negedge clk);
    chk("abort_enable_c1", 32'(enable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_enable", 32'(enable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    m_up = m_up + 4'd2; m_down = m_down - 4'd2;
    chk("abort_pair_up", 32'(pair_up), 32'(m_up));
    chk("abort_pair_down", 32'(pair_down), 32'(m_down));
    rst = 1'b0; m_ptr = NR - 1;
    run_txn(2'b11, 2'b00, 8'h22, 1'b1);

    // Converging values: early stop only when the feature is built in
    preload(4'd6, 4'd10);
    run_txn(2'b10, 2'b00, 8'h80, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) preload(VW'($urandom), VW'($urandom));
      run_txn(NR'($urandom), NR'($urandom), (NR*LW)'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
